pin_collector: RTL and testbench

Parametrised PIN-entry assembler between the keypad decoder and the password checker/FSM. It collects a variable-length PIN of MIN_DIGITS..MAX_DIGITS decimal digits from edge-detected key events and supports backspace, clear and enter. It presents the finished PIN through a valid/ready handshake, and can optionally discard a stale partial entry after an inactivity timeout.

---
 rtl/pin_pkg.sv | 16 +
 rtl/key_edge.sv | 19 +
 rtl/pin_collector.sv | 132 +++++++++++++
 tb/tb_pin_collector.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pin_pkg.sv
// Shared PIN-entry definitions: blank slot code, default key codes, collector states
// and the digit classifier.
package pin_pkg;

  localparam logic [3:0] BLANK          = 4'hE;
  localparam logic [3:0] KEY_BACK_DEF   = 4'hA;
  localparam logic [3:0] KEY_CLEAR_DEF  = 4'hB;
  localparam logic [3:0] KEY_ENTER_DEF  = 4'hF;

  typedef enum logic [1:0] {EMPTY, ENTRY, PRESENT} pin_state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/key_edge.sv
// Turns a key-present level into a one-cycle pulse on its rising edge; a held key
// yields exactly one pulse.
module key_edge (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  logic level_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_prev <= 1'b0;
    else     level_prev <= level;
  end

  assign pulse = level & ~level_prev;

endmodule

// File: rtl/pin_collector.sv
// Variable-length PIN assembler with backspace/clear/enter and a valid/ready output.
// Optional inactivity clear is built when PIN_TIMEOUT_EN is defined.
module pin_collector
  import pin_pkg::*;
#(
  parameter int         MAX_DIGITS  = 8,
  parameter int         MIN_DIGITS  = 4,
  parameter logic [3:0] KEY_BACK    = KEY_BACK_DEF,
  parameter logic [3:0] KEY_CLEAR   = KEY_CLEAR_DEF,
  parameter logic [3:0] KEY_ENTER   = KEY_ENTER_DEF,
  parameter int         TIMEOUT_CYC = 5000
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                key_valid,
  input  logic [3:0]                          key_code,
  input  logic                                pin_ready_i,
  output logic [4*MAX_DIGITS-1:0]             digits_o,
  output logic [$clog2(MAX_DIGITS+1)-1:0]     len_o,
  output logic                                pin_valid_o,
  output logic                                err_o,
  output logic                                timeout_o
);

  localparam int               LEN_W   = $clog2(MAX_DIGITS + 1);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_DIGITS);
  localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(MIN_DIGITS);
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

  pin_state_t       state, nxt_state;
  logic [3:0]       dig_q   [MAX_DIGITS];
  logic [3:0]       nxt_dig [MAX_DIGITS];
  logic [LEN_W-1:0] len_q, nxt_len;
  logic             err_q, nxt_err;
  logic             ev, to_hit;

  key_edge u_key_edge (
    .clk   (clk),
    .rst   (rst),
    .level (key_valid),
    .pulse (ev)
  );

`ifdef PIN_TIMEOUT_EN
  localparam int               CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] idle_cnt;
  logic             to_q;

  // A key event in the expiry cycle takes priority over the timeout.
  assign to_hit = (state == ENTRY) && !ev && (idle_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
      to_q     <= 1'b0;
    end else begin
      to_q <= to_hit;
      if (ev || (state != ENTRY) || (nxt_state != state)) idle_cnt <= '0;
      else                                                idle_cnt <= idle_cnt + CNT_W'(1);
    end
  end

  assign timeout_o = to_q;
`else
  assign to_hit    = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    nxt_dig   = dig_q;
    nxt_len   = len_q;
    nxt_state = state;
    nxt_err   = 1'b0;
    if (state == PRESENT) begin
      if (pin_ready_i) begin
        for (int i = 0; i < MAX_DIGITS; i++) nxt_dig[i] = BLANK;
        nxt_len   = '0;
        nxt_state = EMPTY;
      end
    end else if (ev) begin
      if (is_digit(key_code)) begin
        for (int i = MAX_DIGITS - 1; i > 0; i--) nxt_dig[i] = dig_q[i-1];
        nxt_dig[0] = key_code;
        if (len_q != MAX_LEN) nxt_len = len_q + ONE;
        nxt_state = ENTRY;
      end else if (key_code == KEY_BACK) begin
        if (state == ENTRY) begin
          for (int i = 0; i < MAX_DIGITS - 1; i++) nxt_dig[i] = dig_q[i+1];
          nxt_dig[MAX_DIGITS-1] = BLANK;
          nxt_len = len_q - ONE;
          if (len_q == ONE) nxt_state = EMPTY;
        end
      end else if (key_code == KEY_CLEAR) begin
        for (int i = 0; i < MAX_DIGITS; i++) nxt_dig[i] = BLANK;
        nxt_len   = '0;
        nxt_state = EMPTY;
      end else if (key_code == KEY_ENTER) begin
        if ((state == ENTRY) && (len_q >= MIN_LEN)) nxt_state = PRESENT;
        else                                        nxt_err   = 1'b1;
      end
    end else if (to_hit) begin
      for (int i = 0; i < MAX_DIGITS; i++) nxt_dig[i] = BLANK;
      nxt_len   = '0;
      nxt_state = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      len_q <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < MAX_DIGITS; i++) dig_q[i] <= BLANK;
    end else begin
      state <= nxt_state;
      len_q <= nxt_len;
      err_q <= nxt_err;
      dig_q <= nxt_dig;
    end
  end

  for (genvar g = 0; g < MAX_DIGITS; g++) begin : g_digits
    assign digits_o[4*g +: 4] = dig_q[g];
  end

  assign len_o       = len_q;
  assign pin_valid_o = (state == PRESENT);
  assign err_o       = err_q;

endmodule

// File: tb/tb_pin_collector.sv
// Bench for pin_collector: directed vector table, reset cases, timeout cases
// (with PIN_TIMEOUT_EN) and random keys against a queue-based reference model.
module tb_pin_collector;

  localparam int MAXD = 8;
  localparam int MIND = 4;
  localparam int TO   = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        pin_ready_i;
  logic [31:0] digits_o;
  logic [3:0]  len_o;
  logic        pin_valid_o;
  logic        err_o;
  logic        timeout_o;

  always #5 clk = ~clk;

  pin_collector #(
    .MAX_DIGITS  (MAXD),
    .MIN_DIGITS  (MIND),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .pin_ready_i (pin_ready_i),
    .digits_o    (digits_o),
    .len_o       (len_o),
    .pin_valid_o (pin_valid_o),
    .err_o       (err_o),
    .timeout_o   (timeout_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: newest digit at the front of the queue.
  logic [3:0] q[$];
  bit         m_pres;
  bit         m_prev;
  int         m_idle;
  bit         e_err;
  bit         e_to;

  typedef struct {
    bit          kv;
    logic [3:0]  kc;
    bit          rdy;
    int          len;
    logic [31:0] lo;
    bit          val;
    bit          err;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_digits();
    logic [31:0] r;
    for (int i = 0; i < MAXD; i++) r[4*i +: 4] = (i < q.size()) ? q[i] : 4'hE;
    return r;
  endfunction

  function automatic int model_st();
    return m_pres ? 2 : ((q.size() > 0) ? 1 : 0);
  endfunction

  task automatic model_reset();
    q.delete();
    m_pres = 0;
    m_prev = 0;
    m_idle = 0;
    e_err  = 0;
    e_to   = 0;
  endtask

  task automatic model_step(input bit kv, input logic [3:0] kc, input bit rdy);
    bit ev;
    int old_st, new_st;
    ev     = kv && !m_prev;
    m_prev = kv;
    e_err  = 0;
    e_to   = 0;
    old_st = model_st();
    if (m_pres) begin
      if (rdy) begin
        m_pres = 0;
        q.delete();
      end
    end else if (ev) begin
      if (kc <= 4'd9) begin
        q.push_front(kc);
        if (q.size() > MAXD) void'(q.pop_back());
      end else if (kc == 4'hA) begin
        if (q.size() > 0) void'(q.pop_front());
      end else if (kc == 4'hB) begin
        q.delete();
      end else if (kc == 4'hF) begin
        if (q.size() >= MIND) m_pres = 1;
        else                  e_err  = 1;
      end
    end
`ifdef PIN_TIMEOUT_EN
    else if (q.size() > 0 && m_idle == TO - 1) begin
      q.delete();
      e_to = 1;
    end
`endif
    new_st = model_st();
    if (ev || old_st != new_st || new_st != 1) m_idle = 0;
    else                                       m_idle++;
  endtask

  task automatic check_model();
    chk("digits", digits_o, model_digits());
    chk("len", 32'(len_o), 32'(q.size()));
    chk("pin_valid", 32'(pin_valid_o), 32'(m_pres));
    chk("err", 32'(err_o), 32'(e_err));
    chk("timeout", 32'(timeout_o), 32'(e_to));
  endtask

  task automatic cyc(input bit kv, input logic [3:0] kc, input bit rdy);
    @(negedge clk);
    key_valid   = kv;
    key_code    = kc;
    pin_ready_i = rdy;
    @(posedge clk);
    model_step(kv, kc, rdy);
    #1;
    check_model();
  endtask

  function automatic void add(input bit kv, input logic [3:0] kc, input bit rdy,
                              input int len, input logic [31:0] lo, input bit val, input bit err);
    vec_t v;
    v.kv = kv; v.kc = kc; v.rdy = rdy; v.len = len; v.lo = lo; v.val = val; v.err = err;
    tbl.push_back(v);
  endfunction

  function automatic void press(input logic [3:0] kc, input bit rdy, input int len,
                                input logic [31:0] lo, input bit val, input bit err);
    add(1, kc, rdy, len, lo, val, err);
    add(0, kc, rdy, len, lo, val, 0);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    key_valid = 1'b0;
    #1;
    model_reset();
    check_model();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_lo;
    rst = 1'b1; key_valid = 1'b0; key_code = 4'h0; pin_ready_i = 1'b0;
    #12;
    model_reset();
    check_model();
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors
    press(4'h1, 0, 1, 32'hEEEEEEE1, 0, 0);
    press(4'h2, 0, 2, 32'hEEEEEE12, 0, 0);
    press(4'h3, 0, 3, 32'hEEEEE123, 0, 0);
    press(4'hF, 0, 3, 32'hEEEEE123, 0, 1);
    press(4'h4, 0, 4, 32'hEEEE1234, 0, 0);
    press(4'hF, 0, 4, 32'hEEEE1234, 1, 0);
    for (int i = 0; i < 10; i++) add(0, 4'h0, 0, 4, 32'hEEEE1234, 1, 0);
    press(4'h5, 0, 4, 32'hEEEE1234, 1, 0);
    add(0, 4'h0, 1, 0, 32'hEEEEEEEE, 0, 0);
    exp_lo = 32'hEEEEEEEE;
    for (int d = 1; d <= 9; d++) begin
      exp_lo = {exp_lo[27:0], 4'(d)};
      press(4'(d), 0, (d < MAXD) ? d : MAXD, exp_lo, 0, 0);
    end
    press(4'hA, 0, 7, 32'hE2345678, 0, 0);
    press(4'hB, 0, 0, 32'hEEEEEEEE, 0, 0);
    for (int i = 0; i < 50; i++) add(1, 4'h5, 0, 1, 32'hEEEEEEE5, 0, 0);
    add(0, 4'h5, 0, 1, 32'hEEEEEEE5, 0, 0);
    press(4'hB, 0, 0, 32'hEEEEEEEE, 0, 0);
    press(4'hA, 0, 0, 32'hEEEEEEEE, 0, 0);
    press(4'hF, 0, 0, 32'hEEEEEEEE, 0, 1);
    press(4'h7, 0, 1, 32'hEEEEEEE7, 0, 0);
    press(4'hC, 0, 1, 32'hEEEEEEE7, 0, 0);
    press(4'hD, 0, 1, 32'hEEEEEEE7, 0, 0);
    press(4'hE, 0, 1, 32'hEEEEEEE7, 0, 0);
    press(4'h1, 1, 2, 32'hEEEEEE71, 0, 0);
    press(4'h2, 1, 3, 32'hEEEEE712, 0, 0);
    press(4'hF, 1, 3, 32'hEEEEE712, 0, 1);
    press(4'h3, 1, 4, 32'hEEEE7123, 0, 0);
    add(1, 4'hF, 1, 4, 32'hEEEE7123, 1, 0);
    add(0, 4'hF, 1, 0, 32'hEEEEEEEE, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].kv, tbl[i].kc, tbl[i].rdy);
      chk($sformatf("tbl%0d_len", i), 32'(len_o), 32'(tbl[i].len));
      chk($sformatf("tbl%0d_digits", i), digits_o, tbl[i].lo);
      chk($sformatf("tbl%0d_valid", i), 32'(pin_valid_o), 32'(tbl[i].val));
      chk($sformatf("tbl%0d_err", i), 32'(err_o), 32'(tbl[i].err));
    end

    // Reset mid-entry and during presentation
    cyc(1, 4'h1, 0); cyc(0, 4'h0, 0); cyc(1, 4'h2, 0); cyc(0, 4'h0, 0);
    do_reset();
    chk("rst_mid_len", 32'(len_o), 32'd0);
    for (int d = 1; d <= 4; d++) begin cyc(1, 4'(d), 0); cyc(0, 4'h0, 0); end
    cyc(1, 4'hF, 0); cyc(0, 4'h0, 0);
    chk("present_before_rst", 32'(pin_valid_o), 32'd1);
    do_reset();
    chk("rst_present_valid", 32'(pin_valid_o), 32'd0);
    chk("rst_present_digits", digits_o, 32'hEEEEEEEE);

`ifdef PIN_TIMEOUT_EN
    cyc(1, 4'h7, 0);
    for (int k = 1; k <= TO; k++) begin
      cyc(0, 4'h0, 0);
      chk($sformatf("to_pulse_k%0d", k), 32'(timeout_o), (k == TO) ? 32'd1 : 32'd0);
      chk($sformatf("to_len_k%0d", k), 32'(len_o), (k == TO) ? 32'd0 : 32'd1);
    end
    cyc(0, 4'h0, 0);
    chk("to_pulse_end", 32'(timeout_o), 32'd0);
    cyc(1, 4'h7, 0);
    for (int k = 1; k < TO; k++) cyc(0, 4'h0, 0);
    cyc(1, 4'h3, 0);
    chk("to_race_pulse", 32'(timeout_o), 32'd0);
    chk("to_race_len", 32'(len_o), 32'd2);
    chk("to_race_digits", digits_o, 32'hEEEEEE73);
    cyc(0, 4'h0, 0); cyc(1, 4'hB, 0); cyc(0, 4'h0, 0);
`endif

    // Random keys against the model
    for (int i = 0; i < 4000; i++) begin
      logic [3:0] kc;
      kc = ($urandom_range(0, 9) < 6) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
      if ((i % 1000) == 999) begin
        for (int k = 0; k < TO + 5; k++) cyc(0, 4'h0, 1'($urandom_range(0, 3) == 0));
      end else begin
        cyc(1'($urandom_range(0, 1)), kc, 1'($urandom_range(0, 3) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
